fifo_rd_ctrl: RTL and testbench

- Read-side controller for fifo_mem. It drains a programmed burst of words from the FIFO and presents them downstream on a valid/ready stream.
- It drives the FIFO's trans_read and absorbs the FIFO's 1-cycle read latency with a 2-entry skid buffer.
- Sustains one word per cycle when the FIFO is non-empty and the sink is ready.
- Sits between fifo_mem and any consumer block.

---
 rtl/fifo_rd_pkg.sv | 34 +++
 rtl/fifo_rd_skid.sv | 63 ++++++
 rtl/fifo_rd_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// ---------------------------------------------------------------------------
// fifo_rd_pkg
// Shared definitions for the fifo_mem read-side controller (fifo_rd_ctrl) and
// its skid buffer (fifo_rd_skid).
//   state_e       controller FSM states (2-bit)
//   SKID_DEPTH    entries in the skid buffer
//   STALL_CNT_W   width of the optional stall statistics counter
//   can_issue()   true when one more read can be launched without the
//                 skid buffer overflowing
// ---------------------------------------------------------------------------
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int SKID_DEPTH  = 2;
    localparam int STALL_CNT_W = 16;

    // Words already buffered plus the word still inside the FIFO's read
    // pipeline, minus the word leaving this cycle, must leave one free slot
    // for the read about to be issued.
    function automatic logic can_issue(input logic [1:0] count,
                                       input logic       inflight,
                                       input logic       pop);
        logic [2:0] occ;
        occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        return occ < 3'(SKID_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// ---------------------------------------------------------------------------
// fifo_rd_skid
// Two-entry circular buffer that absorbs the one-cycle read latency of
// fifo_mem. Simultaneous push and pop keep the count unchanged and preserve
// order. head_data always shows the oldest entry.
// Ports:
//   clk_in     in   clock, rising edge
//   areset_b   in   synchronous active-low reset
//   push       in   write push_data at the end of this cycle
//   push_data  in   word to store
//   pop        in   drop the head entry at the end of this cycle
//   count      out  number of stored entries (0..2)
//   head_data  out  oldest stored entry
// ---------------------------------------------------------------------------
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_in,
    input  logic                  areset_b,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic [1:0]            count_d;

    assign count_d   = count_q + {1'b0, push} - {1'b0, pop};
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk_in) begin
        if (!areset_b) begin
            // NOTE: the storage is only two words, so it is cleared on reset to
            // make the downstream data read zero after reset instead of stale.
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side controller for fifo_mem. Drains a programmed burst of words from
// the FIFO and presents them on a valid/ready stream, one word per cycle when
// the FIFO has data and the sink is ready. The FIFO's one-cycle read latency
// is absorbed by a two-entry skid buffer (fifo_rd_skid).
//
// Build option: define FIFO_RD_STALL_STATS_EN to add the stall_cnt output,
// a saturating count of busy cycles where m_valid=1 and m_ready=0.
//
// Ports:
//   clk_in          in   clock, rising edge
//   areset_b        in   synchronous active-low reset
//   start           in   begin a burst (ignored unless idle)
//   burst_len       in   words to drain, sampled with start
//   busy            out  burst in progress
//   done            out  one-cycle pulse once the burst is fully delivered
//   err             out  sticky: fifo_underflow seen while busy
//   fifo_read       out  to fifo_mem trans_read
//   fifo_data       in   from fifo_mem data_out, valid the cycle after a read
//   fifo_empty      in   from fifo_mem empty_ind
//   fifo_underflow  in   from fifo_mem underflow_ind
//   m_valid         out  downstream data valid
//   m_data          out  downstream data (skid buffer head)
//   m_ready         in   downstream accept
//   stall_cnt       out  (FIFO_RD_STALL_STATS_EN only) stall cycle count
// ---------------------------------------------------------------------------
module fifo_rd_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk_in,
    input  logic                  areset_b,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  fifo_read,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
`ifdef FIFO_RD_STALL_STATS_EN
   ,output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] issue_rem_q, issue_rem_d;
    logic [LEN_WIDTH-1:0] deliv_rem_q, deliv_rem_d;
    logic                 inflight_q;
    logic                 err_q, err_d;
    logic [1:0]           skid_count;
    logic                 pop;
    logic                 start_ok;

    assign m_valid  = (skid_count != 2'd0);
    assign pop      = m_valid & m_ready;
    assign busy     = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done     = (state_q == ST_DONE);
    assign err      = err_q;
    assign start_ok = (state_q == ST_IDLE) && start;

    assign fifo_read = (state_q == ST_RUN) && (issue_rem_q != '0) && !fifo_empty
                       && can_issue(skid_count, inflight_q, pop);

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk_in    (clk_in),
        .areset_b  (areset_b),
        .push      (inflight_q),
        .push_data (fifo_data),
        .pop       (pop),
        .count     (skid_count),
        .head_data (m_data)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through
        // the case statement leaves it unassigned (which would infer a latch).
        state_d     = state_q;
        issue_rem_d = issue_rem_q - LEN_WIDTH'(fifo_read);
        deliv_rem_d = deliv_rem_q - LEN_WIDTH'(pop);
        err_d       = err_q | (busy & fifo_underflow);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (burst_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        issue_rem_d = burst_len;
                        deliv_rem_d = burst_len;
                        state_d     = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (issue_rem_d == '0) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // deliv_rem counts issued-but-not-popped words too, so reaching
                // zero means nothing is in flight and the buffer is empty.
                // Looking at the next value lets done follow the last pop
                // directly.
                if (deliv_rem_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!areset_b) begin
            state_q     <= ST_IDLE;
            issue_rem_q <= '0;
            deliv_rem_q <= '0;
            inflight_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_rem_q <= issue_rem_d;
            deliv_rem_q <= deliv_rem_d;
            inflight_q  <= fifo_read;
            err_q       <= err_d;
        end
    end

`ifdef FIFO_RD_STALL_STATS_EN
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_ok) begin
            stall_d = '0;
        end else if (busy && m_valid && !m_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!areset_b) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    // start_ok only feeds the stall counter.
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_ctrl
// Self-checking bench for fifo_rd_ctrl. A queue-based model of fifo_mem feeds
// the DUT; a transaction-level reference (words issued but not yet popped,
// each becoming visible two cycles after its read) predicts every output each
// cycle. Directed scenarios are followed by randomized bursts.
// ---------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

    localparam int DW = 16;
    localparam int LW = 8;

    logic          clk_in = 1'b0;
    logic          areset_b = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          busy, done, err, fifo_read;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_underflow = 1'b0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;
`ifdef FIFO_RD_STALL_STATS_EN
    logic [15:0]   stall_cnt;
`endif

    always #5 clk_in = ~clk_in;

    fifo_rd_ctrl #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk_in         (clk_in),
        .areset_b       (areset_b),
        .start          (start),
        .burst_len      (burst_len),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .fifo_read      (fifo_read),
        .fifo_data      (fifo_data),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready)
`ifdef FIFO_RD_STALL_STATS_EN
       ,.stall_cnt      (stall_cnt)
`endif
    );

    // ---------------- reference model state ----------------
    typedef struct {
        logic [DW-1:0] w;
        int            rdy;
    } pend_t;

    logic [DW-1:0] fifo_q[$];
    pend_t         pend_q[$];
    logic [DW-1:0] fifo_dout = '0;
    logic [DW-1:0] next_word = 16'h0001;
    int            phase = 0;       // 0 idle, 1 busy, 2 done pulse
    int            issue_left = 0;
    int            deliv_left = 0;
    bit            err_e = 1'b0;
    int            stall_e = 0;
    int            cyc = 0;
    int            read_seen = 0;
    int            done_seen = 0;
    bit            chk_data_zero = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(next_word);
            next_word++;
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model to the state after the coming rising edge.
    task automatic step(input bit st, input int len, input bit rdy, input bit uf, input bit push);
        bit            mv_e, pop_e, rd_e;
        pend_t         p;
        logic [DW-1:0] word;
        @(negedge clk_in);
        areset_b       = 1'b1;
        start          = st;
        burst_len      = LW'(len);
        m_ready        = rdy;
        fifo_underflow = uf;
        fifo_empty     = (fifo_q.size() == 0);
        fifo_data      = fifo_dout;
        #1;
        mv_e  = (pend_q.size() > 0) && (pend_q[0].rdy <= cyc);
        pop_e = mv_e && rdy;
        rd_e  = (phase == 1) && (issue_left > 0) && (fifo_q.size() > 0)
                && ((pend_q.size() - int'(pop_e)) < 2);

        check("busy",      32'(busy),      32'(phase == 1));
        check("done",      32'(done),      32'(phase == 2));
        check("err",       32'(err),       32'(err_e));
        check("m_valid",   32'(m_valid),   32'(mv_e));
        check("fifo_read", 32'(fifo_read), 32'(rd_e));
        if (mv_e) check("m_data", 32'(m_data), 32'(pend_q[0].w));
        else if (chk_data_zero) check("m_data_rst", 32'(m_data), 32'h0);
        chk_data_zero = 1'b0;
`ifdef FIFO_RD_STALL_STATS_EN
        check("stall_cnt", 32'(stall_cnt), 32'(stall_e));
`endif
        if (fifo_read) read_seen++;
        if (done) done_seen++;

        if ((phase == 1) && uf) err_e = 1'b1;
        if ((phase == 0) && st) stall_e = 0;
        else if ((phase == 1) && mv_e && !rdy && (stall_e < 'hFFFF)) stall_e++;

        if (pop_e) begin
            void'(pend_q.pop_front());
            deliv_left--;
        end
        if (rd_e) begin
            word  = fifo_q.pop_front();
            p.w   = word;
            p.rdy = cyc + 2;
            pend_q.push_back(p);
            issue_left--;
            fifo_dout = word;
        end else begin
            fifo_dout = 16'($urandom);   // data_out is meaningless without a read
        end

        case (phase)
            0: if (st) begin
                if (len == 0) phase = 2;
                else begin
                    phase      = 1;
                    issue_left = len;
                    deliv_left = len;
                end
            end
            1: if (deliv_left == 0) phase = 2;
            default: phase = 0;
        endcase

        if (push) begin
            fifo_q.push_back(next_word);
            next_word++;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        areset_b       = 1'b0;
        start          = 1'b0;
        m_ready        = 1'b0;
        fifo_underflow = 1'b0;
        fifo_empty     = (fifo_q.size() == 0);
        @(posedge clk_in);
        pend_q.delete();
        phase         = 0;
        issue_left    = 0;
        deliv_left    = 0;
        err_e         = 1'b0;
        stall_e       = 0;
        chk_data_zero = 1'b1;
        cyc++;
    endtask

    // Run until the model returns to idle; spurious starts are sprinkled in
    // and must be ignored.
    task automatic run_idle(input int rdy_pct, input int push_pct, input int max_cyc);
        int n;
        n = 0;
        while ((phase != 0) && (n < max_cyc)) begin
            step($urandom_range(0, 9) == 0, int'($urandom_range(0, 255)),
                 $urandom_range(1, 100) <= rdy_pct, 1'b0,
                 $urandom_range(1, 100) <= push_pct);
            n++;
        end
        if (phase != 0) check("burst_timeout", 32'(phase), 32'h0);
    endtask

    initial begin
        int n;
        int len;
        do_reset();
        do_reset();
        step(0, 0, 1, 0, 0);

        // Burst of 5 from a preloaded FIFO with a ready sink.
        preload(5);
        read_seen = 0;
        done_seen = 0;
        step(1, 5, 1, 0, 0);
        run_idle(100, 0, 100);
        step(0, 0, 1, 0, 0);
        check("t1_reads", 32'(read_seen), 32'd5);
        check("t1_done_pulses", 32'(done_seen), 32'd1);

        // Zero-length burst: no reads although the FIFO has data.
        preload(2);
        read_seen = 0;
        done_seen = 0;
        step(1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        check("t2_reads", 32'(read_seen), 32'd0);
        check("t2_done_pulses", 32'(done_seen), 32'd1);

        // Four words, sink stalled: only two reads fit, head held stable.
        preload(2);
        read_seen = 0;
        step(1, 4, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
        check("t3_reads_stalled", 32'(read_seen), 32'd2);
        run_idle(100, 0, 100);
`ifdef FIFO_RD_STALL_STATS_EN
        step(0, 0, 1, 0, 0);
        check("t3_stall_cnt_hold", 32'(stall_cnt), 32'd6);
`endif

        // Empty FIFO, trickle one word every 4 cycles.
        step(1, 3, 1, 0, 0);
        n = 0;
        while ((phase != 0) && (n < 60)) begin
            step(0, 0, 1, 0, (n % 4) == 0);
            n++;
        end
        if (phase != 0) check("t4_timeout", 32'(phase), 32'h0);

        // Reset mid-burst after two deliveries, then a fresh burst of 2.
        preload(8);
        step(1, 8, 1, 0, 0);
        n = 0;
        while ((deliv_left > 6) && (n < 20)) begin
            step(0, 0, 1, 0, 0);
            n++;
        end
        do_reset();
        step(0, 0, 1, 0, 0);
        step(1, 2, 1, 0, 0);
        run_idle(100, 0, 50);

        // Underflow while idle is ignored; while busy it sets a sticky err.
        step(0, 0, 1, 1, 0);
        preload(3);
        step(1, 3, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        run_idle(100, 0, 50);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        check("t6_err_sticky", 32'(err), 32'h1);
        do_reset();
        step(0, 0, 1, 0, 0);

        // Randomized bursts, including the maximum length.
        for (int b = 0; b < 40; b++) begin
            len = (b == 20) ? 255 : int'($urandom_range(0, 12));
            for (int i = 0; i < int'($urandom_range(0, 3)); i++)
                step(0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 1) == 1);
            step(1, len, $urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 1) == 1);
            run_idle(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 3000);
        end
        step(0, 0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
